// File: rtl/mio_responder_pkg.sv
// mio_pkg: shared constants for the CPU data-side responder.
// Address map, FSM encoding and wait-counter width.
package mio_pkg;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hE000_0000;
  localparam logic [31:0] LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

  localparam int WCW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

endpackage

// File: rtl/mio_responder_if.sv
// mio_if: CPU data-side request/acknowledge bus.
// master = CPU (drives request), slave = responder (drives data/ready).
interface mio_if;

  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, Addr_out, Data_out,
    input  Data_in, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, Addr_out, Data_out,
    output Data_in, MIO_ready
  );

endinterface

// File: rtl/mio_responder_ram.sv
// mio_ram: 2^AW x 32 data RAM, sync write, async read, no reset.
// Ports: clk, we, addr (word index), wdata, rdata.
module mio_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mio_responder.sv
// mio_responder: wait-stated RAM/peripheral responder for the CPU.
// Ports: clk, rst, bus (mio_if.slave), sw_in, led_out, bus_err.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mio_if.slave        bus,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_err
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [WCW-1:0] WLOAD =
    WCW'(NO_WAIT ? 0 : WAIT_CYCLES - 1);

  state_t         state, state_nx;
  logic [WCW-1:0] wcnt, wcnt_nx;
  logic           accept, commit;

  logic           rq_rw;
  logic [31:0]    rq_addr, rq_data;

  logic           eff_rw;
  logic [31:0]    eff_addr, eff_data;

  logic           hit_ram, hit_sw, hit_led, hit_cnt;
  logic           hit_any, wr;
  logic [31:0]    ram_rdata, rd_mux, cnt;
  logic           unused_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    accept   = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.CPU_MIO) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            state_nx = ACK;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            wcnt_nx  = WLOAD;
          end
        end
      end
      WAIT: begin
        if (wcnt == '0) begin
          state_nx = ACK;
          commit   = 1'b1;
        end else begin
          wcnt_nx = wcnt - 1'b1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.MIO_ready = (state == ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_rw   <= 1'b0;
      rq_addr <= '0;
      rq_data <= '0;
    end else if (accept) begin
      rq_rw   <= bus.MemRW;
      rq_addr <= bus.Addr_out;
      rq_data <= bus.Data_out;
    end
  end

  // Zero-wait builds commit in IDLE, before the latch is loaded.
  assign eff_rw   = (state == IDLE) ? bus.MemRW    : rq_rw;
  assign eff_addr = (state == IDLE) ? bus.Addr_out : rq_addr;
  assign eff_data = (state == IDLE) ? bus.Data_out : rq_data;

  assign hit_ram = eff_addr[31:RAM_AW+2]
                == RAM_BASE[31:RAM_AW+2];
  assign hit_sw  = eff_addr[31:2] == SW_ADDR[31:2];
  assign hit_led = eff_addr[31:2] == LED_ADDR[31:2];
  assign hit_cnt = eff_addr[31:2] == CNT_ADDR[31:2];
  assign hit_any = hit_ram | hit_sw | hit_led | hit_cnt;
  assign wr      = commit & eff_rw;

  assign unused_ok = ^eff_addr[1:0];

  mio_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (wr & hit_ram),
    .addr  (eff_addr[RAM_AW+1:2]),
    .wdata (eff_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_ram: rd_mux = ram_rdata;
      hit_sw:  rd_mux = {16'b0, sw_in};
      hit_led: rd_mux = {16'b0, led_out};
      hit_cnt: rd_mux = cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Data_in <= '0;
      led_out     <= '0;
      cnt         <= '0;
      bus_err     <= 1'b0;
    end else begin
      if (commit && !eff_rw) bus.Data_in <= rd_mux;
      if (wr && hit_led) led_out <= eff_data[15:0];
      // A load on the same edge overrides the increment.
      if (wr && hit_cnt) cnt <= eff_data;
      else               cnt <= cnt + 32'd1;
      if (commit && !hit_any) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: vector-table bench for mio_responder.
// Covers wait-stated DUT (2) and zero-wait DUT under back-to-back requests.
module tb_mio_responder;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    logic [31:0] exp_d;
    logic [15:0] exp_led;
    logic        exp_err;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        rst2 = 1'b1;
  logic [15:0] sw   = 16'h0;
  logic [15:0] led, led2;
  logic        err, err2;

  int n_chk  = 0;
  int n_fail = 0;

  mio_if bus ();
  mio_if bus2 ();

  mio_responder #(.RAM_AW(10), .WAIT_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw_in   (sw),
    .led_out (led),
    .bus_err (err)
  );

  mio_responder #(.RAM_AW(10), .WAIT_CYCLES(0)) dut0 (
    .clk     (clk),
    .rst     (rst2),
    .bus     (bus2),
    .sw_in   (sw),
    .led_out (led2),
    .bus_err (err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the FSM idle; returns at the ACK negedge.
  // The request is dropped and the bus scrambled after acceptance,
  // so completion must come from the latched copy.
  task automatic do_access(input logic rw,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           output int lat);
    bus.CPU_MIO  = 1'b1;
    bus.MemRW    = rw;
    bus.Addr_out = a;
    bus.Data_out = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.CPU_MIO  = 1'b0;
      bus.MemRW    = 1'b1;
      bus.Addr_out = 32'h8000_0000;
      bus.Data_out = 32'h0;
    end while (!bus.MIO_ready && lat < 10);
  endtask

  vec_t tv [18];

  initial begin
    int lat;

    tv[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h1234,
               32'h0000_0000, 16'h0000, 1'b0};
    tv[1]  = '{1'b0, 32'h0000_0010, 32'h0, 16'h1234,
               32'hDEAD_BEEF, 16'h0000, 1'b0};
    tv[2]  = '{1'b1, 32'hF000_0000, 32'h1234_A5A5, 16'h1234,
               32'hDEAD_BEEF, 16'hA5A5, 1'b0};
    tv[3]  = '{1'b0, 32'hE000_0000, 32'h0, 16'h1234,
               32'h0000_1234, 16'hA5A5, 1'b0};
    tv[4]  = '{1'b0, 32'hF000_0000, 32'h0, 16'h1234,
               32'h0000_A5A5, 16'hA5A5, 1'b0};
    tv[5]  = '{1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 16'h1234,
               32'h0000_A5A5, 16'hA5A5, 1'b0};
    tv[6]  = '{1'b0, 32'hE000_0000, 32'h0, 16'hBEEF,
               32'h0000_BEEF, 16'hA5A5, 1'b0};
    tv[7]  = '{1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 16'h1234,
               32'h0000_BEEF, 16'hA5A5, 1'b0};
    tv[8]  = '{1'b0, 32'h0000_0010, 32'h0, 16'h1234,
               32'hDEAD_BEEF, 16'hA5A5, 1'b0};
    // Loaded at commit edge P, read commits at P+8: FFFF_FFFE + 7.
    tv[9]  = '{1'b0, 32'hF000_0004, 32'h0, 16'h1234,
               32'h0000_0005, 16'hA5A5, 1'b0};
    tv[10] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 16'h1234,
               32'h0000_0005, 16'hA5A5, 1'b0};
    tv[11] = '{1'b0, 32'h0000_0FFC, 32'h0, 16'h1234,
               32'h1234_5678, 16'hA5A5, 1'b0};
    tv[12] = '{1'b0, 32'h0000_0013, 32'h0, 16'h1234,
               32'hDEAD_BEEF, 16'hA5A5, 1'b0};
    tv[13] = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 16'h1234,
               32'hDEAD_BEEF, 16'hA5A5, 1'b0};
    tv[14] = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 16'h1234,
               32'hDEAD_BEEF, 16'hA5A5, 1'b0};
    tv[15] = '{1'b0, 32'h8000_0000, 32'h0, 16'h1234,
               32'h0000_0000, 16'hA5A5, 1'b1};
    tv[16] = '{1'b1, 32'h0000_1000, 32'h5555_5555, 16'h1234,
               32'h0000_0000, 16'hA5A5, 1'b1};
    tv[17] = '{1'b0, 32'h0000_0000, 32'h0, 16'h1234,
               32'h0BAD_F00D, 16'hA5A5, 1'b1};

    bus.CPU_MIO   = 1'b0;
    bus.MemRW     = 1'b0;
    bus.Addr_out  = 32'h0;
    bus.Data_out  = 32'h0;
    bus2.CPU_MIO  = 1'b0;
    bus2.MemRW    = 1'b0;
    bus2.Addr_out = 32'h0;
    bus2.Data_out = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst ready",   bus.MIO_ready, 0);
    chk("rst data_in", bus.Data_in, 0);
    chk("rst led",     led, 0);
    chk("rst err",     err, 0);
    chk("rst ready0",  bus2.MIO_ready, 0);
    chk("rst data0",   bus2.Data_in, 0);
    rst  = 1'b0;
    rst2 = 1'b0;

    // Zero-wait DUT, request held high: ACK every second cycle.
    bus2.CPU_MIO  = 1'b1;
    bus2.MemRW    = 1'b1;
    bus2.Addr_out = 32'hF000_0004;
    bus2.Data_out = 32'd100;
    @(negedge clk);
    chk("z ack write", bus2.MIO_ready, 1);
    bus2.MemRW = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("z idle %0d", k), bus2.MIO_ready, 0);
      @(negedge clk);
      chk($sformatf("z ack %0d", k), bus2.MIO_ready, 1);
      chk($sformatf("z cnt %0d", k), bus2.Data_in,
          32'd101 + 32'(2 * k));
    end
    bus2.CPU_MIO = 1'b0;
    chk("z err", err2, 0);

    for (int i = 0; i < 18; i++) begin
      sw = tv[i].sw;
      do_access(tv[i].rw, tv[i].addr, tv[i].wdata, lat);
      chk($sformatf("v%0d latency", i), lat, 3);
      chk($sformatf("v%0d data_in", i), bus.Data_in, tv[i].exp_d);
      chk($sformatf("v%0d led", i), led, tv[i].exp_led);
      chk($sformatf("v%0d err", i), err, tv[i].exp_err);
      @(negedge clk);
      chk($sformatf("v%0d ready width", i), bus.MIO_ready, 0);
    end

    // Reset during WAIT of a write: nothing commits, no ACK.
    bus.CPU_MIO  = 1'b1;
    bus.MemRW    = 1'b1;
    bus.Addr_out = 32'h0000_0020;
    bus.Data_out = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    bus.CPU_MIO = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid rst ready %0d", k), bus.MIO_ready, 0);
    end
    chk("mid rst data_in", bus.Data_in, 0);
    chk("mid rst led", led, 0);
    chk("mid rst err", err, 0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post rst ready %0d", k), bus.MIO_ready, 0);
    end
    do_access(1'b0, 32'h0000_0020, 32'h0, lat);
    chk("post rst latency", lat, 3);
    chk("post rst ram", bus.Data_in, 32'hAABB_CCDD);
    chk("post rst err", err, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
